// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer for the ALU shift path: finds the left shift that normalizes an operand,
// one bit per cycle, and reports the normalized value, the shift count and a degenerate flag.
module shift_normalizer #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] w, w_nx, norm_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, shcnt_nx;
  logic             md, md_nx, done_nx, zero_nx;
  logic             degen, normd;

  // mode 1 counts redundant sign bits, so both all-zeros and all-ones have no normalization point
  assign degen = md ? ((w == '0) || (w == '1)) : (w == '0);
  assign normd = md ? (w[WIDTH-1] ^ w[WIDTH-2]) : w[WIDTH-1];
  assign busy  = (state == RUN);

  always_comb begin
    state_nx = state;
    w_nx     = w;
    cnt_nx   = cnt;
    md_nx    = md;
    done_nx  = 1'b0;
    zero_nx  = zero;
    norm_nx  = norm_out;
    shcnt_nx = shift_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          w_nx     = data_in;
          md_nx    = mode;
          cnt_nx   = '0;
          zero_nx  = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if ((cnt == '0) && degen) begin
          done_nx  = 1'b1;
          zero_nx  = 1'b1;
          state_nx = IDLE;
          if (md) begin
            norm_nx  = {w[0], {(WIDTH-1){1'b0}}};
            shcnt_nx = CNT_W'(WIDTH-1);
          end else begin
            norm_nx  = '0;
            shcnt_nx = CNT_W'(WIDTH);
          end
        end else if (normd) begin
          done_nx  = 1'b1;
          norm_nx  = w;
          shcnt_nx = cnt;
          state_nx = IDLE;
        end else begin
          w_nx   = {w[WIDTH-2:0], 1'b0};
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      cnt       <= '0;
      md        <= 1'b0;
      done      <= 1'b0;
      zero      <= 1'b0;
      norm_out  <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_nx;
      w         <= w_nx;
      cnt       <= cnt_nx;
      md        <= md_nx;
      done      <= done_nx;
      zero      <= zero_nx;
      norm_out  <= norm_nx;
      shift_cnt <= shcnt_nx;
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Randomized bench for shift_normalizer: a transaction-level model predicts every output each
// cycle, and directed operations pin both the DUT and the model to hand-computed results.
module tb_shift_normalizer;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [W-1:0]  data_in;
  logic          busy, done, zero;
  logic [W-1:0]  norm_out;
  logic [CW-1:0] shift_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  shift_normalizer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
    .busy(busy), .done(done), .norm_out(norm_out), .shift_cnt(shift_cnt), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of one operation from the rules: count leading zeros (mode 0) or redundant sign bits (mode 1).
  function automatic void model_op(input logic md, input logic [W-1:0] d, output logic [W-1:0] nn,
                                   output logic [CW-1:0] nc, output logic nz, output int lat);
    int n = 0;
    if (!md && d == '0) begin
      nn = '0; nc = CW'(W); nz = 1'b1; lat = 1;
    end else if (md && (d == '0 || d == '1)) begin
      nn = d << (W-1); nc = CW'(W-1); nz = 1'b1; lat = 1;
    end else begin
      if (!md) while (!d[W-1-n]) n++;
      else     while (d[W-2-n] == d[W-1]) n++;
      nn = d << n; nc = CW'(n); nz = 1'b0; lat = 1 + n;
    end
  endfunction

  // Cycle model: what each output must be after every edge
  logic          m_busy, m_done, m_zero;
  logic [W-1:0]  m_norm, r_norm;
  logic [CW-1:0] m_cnt, r_cnt;
  logic          r_zero;
  int            rem, r_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_zero = 0; m_norm = '0; m_cnt = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          model_op(mode, data_in, r_norm, r_cnt, r_zero, r_lat);
          rem = r_lat - 1; m_busy = 1; m_zero = 0;
        end
      end else if (rem == 0) begin
        m_busy = 0; m_done = 1; m_norm = r_norm; m_cnt = r_cnt; m_zero = r_zero;
      end else rem--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("norm_out", 32'(norm_out), 32'(m_norm));
      chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
      chk("zero", 32'(zero), 32'(m_zero));
    end
  end

  // Starts an op at the current negedge, optionally pokes start while busy, and returns
  // at the negedge of the done cycle so a following call exercises back-to-back acceptance.
  task automatic run_op(input string nm, input logic md, input logic [W-1:0] d, input logic [W-1:0] en,
                        input int ec, input logic ez, input int elat, input bit poke);
    int k = 0;
    logic [W-1:0] mn; logic [CW-1:0] mc; logic mz; int ml;
    model_op(md, d, mn, mc, mz, ml);
    chk({nm, " model_norm"}, 32'(mn), 32'(en));
    chk({nm, " model_cnt"}, 32'(mc), 32'(ec));
    start = 1; mode = md; data_in = d;
    @(negedge clk);
    while (!done && k < 40) begin
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      mode = 1'($urandom); data_in = W'($urandom);
      @(negedge clk);
      k++;
    end
    start = 0;
    chk({nm, " done_seen"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(k), 32'(elat));
    chk({nm, " norm_out"}, 32'(norm_out), 32'(en));
    chk({nm, " shift_cnt"}, 32'(shift_cnt), 32'(ec));
    chk({nm, " zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    int ndone;
    logic [W-1:0] r;
    logic md;
    rst = 1; start = 1; mode = 0; data_in = 16'h8000;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 0; start = 0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst outputs", 32'({done, norm_out, shift_cnt, zero}), 32'd0);
    @(negedge clk);
    chk("start_in_rst busy", 32'(busy), 32'd0);

    run_op("m0_0001", 1'b0, 16'h0001, 16'h8000, 15, 1'b0, 16, 1'b1);
    run_op("m0_8000", 1'b0, 16'h8000, 16'h8000, 0, 1'b0, 1, 1'b0);
    run_op("m0_0000", 1'b0, 16'h0000, 16'h0000, 16, 1'b1, 1, 1'b0);
    run_op("m1_fff0", 1'b1, 16'hFFF0, 16'h8000, 11, 1'b0, 12, 1'b1);
    run_op("m1_0003", 1'b1, 16'h0003, 16'h6000, 13, 1'b0, 14, 1'b0);
    run_op("m1_ffff", 1'b1, 16'hFFFF, 16'h8000, 15, 1'b1, 1, 1'b0);
    run_op("m1_0000", 1'b1, 16'h0000, 16'h0000, 15, 1'b1, 1, 1'b0);
    run_op("m1_4000", 1'b1, 16'h4000, 16'h4000, 0, 1'b0, 1, 1'b0);
    @(negedge clk);
    chk("hold after done", 32'({done, norm_out, shift_cnt}), 32'({1'b0, 16'h4000, 5'd0}));

    // Reset in the middle of an operation drops it without a done pulse
    start = 1; mode = 0; data_in = 16'h0001;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst outputs", 32'({busy, done, norm_out, shift_cnt, zero}), 32'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);

    // Random operations; the cycle model checks every output on every cycle
    for (int i = 0; i < 150; i++) begin
      int gap, k;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      md = 1'($urandom);
      r  = W'($urandom);
      case ($urandom_range(0, 3))
        0: r = (i % 4 == 0) ? 16'h0000 : (i % 4 == 1) ? 16'hFFFF : (i % 4 == 2) ? 16'h8000 : 16'h0001;
        1: r = r >> $urandom_range(0, 15);
        2: r = W'($signed(r) >>> $urandom_range(0, 15));
        default: ;
      endcase
      start = 1; mode = md; data_in = r;
      @(negedge clk);
      k = 0;
      while (!done && k < 40) begin
        start = 1'($urandom_range(0, 1)); mode = 1'($urandom); data_in = W'($urandom);
        @(negedge clk);
        k++;
      end
      start = 0;
      if (k >= 40) chk("rand timeout", 32'(k), 32'd17);
    end
    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
